pattern_det_ctrl: RTL and testbench

PATTERN_DET_CTRL -- requirements
Module: pattern_det_ctrl

---
 rtl/pattern_det_pkg.sv | 13 +
 rtl/pattern_det_ctrl_if.sv | 30 +++
 rtl/pattern_match_core.sv | 57 +++++
 rtl/pattern_det_ctrl.sv | 122 ++++++++++++
 tb/tb_pattern_det_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package pattern_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/pattern_det_ctrl_if.sv
// Configuration, control and result signals of the pattern detector.
// valid/ready: bit_in is taken on every rising edge where bit_valid=1 and busy=1; no backpressure.
interface pattern_det_ctrl_if #(
    parameter int MAX_LEN = 8
) ();
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic               start;
    logic               stop;
    logic               bit_in;
    logic               bit_valid;
    logic               ready;
    logic               busy;
    logic               match;
    logic               cfg_err;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_ovl, start, stop, bit_in, bit_valid,
        input  ready, busy, match, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_ovl, start, stop, bit_in, bit_valid,
        output ready, busy, match, cfg_err
    );
endinterface

// File: rtl/pattern_match_core.sv
// Bit history shift register plus masked compare against the stored pattern.
module pattern_match_core #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               restart,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               ovl,
    output logic               hit
);
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] shifted;
    logic [LEN_W-1:0]   fill_next;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        shifted   = (hist_q << 1) | MAX_LEN'(bit_in);
        // fill counts bits since the last clear, saturating once the history is full
        fill_next = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        hit       = shift_en && ((shifted & mask) == (pattern & mask)) && (fill_next >= len);

        hist_d = hist_q;
        fill_d = fill_q;
        if (restart) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            if (hit && !ovl) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = shifted;
                fill_d = fill_next;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/pattern_det_ctrl.sv
// Serial pattern detector control: FSM, configuration registers, match pulse, hit counter.
// Define PATTERN_DET_HIT_CNT_EN to add the saturating hit_cnt output.
module pattern_det_ctrl
    import pattern_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic   clk,
    input  logic   clear,
    pattern_det_ctrl_if.slave bus,
    output state_e dbg_state
`ifdef PATTERN_DET_HIT_CNT_EN
    , output logic [CNT_W-1:0] hit_cnt
`endif
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;
    logic               restart;
    logic               len_ok;
    logic               hit;

    pattern_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
        .clk      (clk),
        .clear    (clear),
        .restart  (restart),
        .shift_en (state_q == RUN && bus.bit_valid),
        .bit_in   (bus.bit_in),
        .pattern  (pat_q),
        .len      (len_q),
        .ovl      (ovl_q),
        .hit      (hit)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cfg_err_d = 1'b0;
        restart   = 1'b0;
        len_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
        // a hit from the current cycle still pulses even if stop leaves RUN now
        match_d   = hit;

        if (bus.cfg_load && state_q != RUN) begin
            if (len_ok) begin
                pat_d = bus.cfg_pattern;
                len_d = bus.cfg_len;
                ovl_d = bus.cfg_ovl;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.cfg_load && len_ok) state_d = READY;
            end
            READY: begin
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
                    restart = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef PATTERN_DET_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (hit && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign hit_cnt = cnt_q;
`endif

    assign bus.ready   = (state_q == READY);
    assign bus.busy    = (state_q == RUN);
    assign bus.match   = match_q;
    assign bus.cfg_err = cfg_err_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Self-checking bench for pattern_det_ctrl: directed scenarios plus random traffic vs a queue-based model.
module tb_pattern_det_ctrl;
    import pattern_det_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic   clk = 1'b0;
    logic   clear;
    state_e dbg_state;
`ifdef PATTERN_DET_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt;
`endif

    pattern_det_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

    pattern_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clear     (clear),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef PATTERN_DET_HIT_CNT_EN
        , .hit_cnt (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses;

    // reference model: mode 0=no pattern, 1=pattern held, 2=detecting
    int           m_mode;
    logic [7:0]   m_pat;
    int           m_len;
    bit           m_ovl;
    logic         m_hist[$];
    int           m_cnt;
    bit           m_match;
    bit           m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pat = '0; m_len = 0; m_ovl = 0;
        m_hist.delete(); m_cnt = 0; m_match = 0; m_err = 0;
    endtask

    task automatic model_update();
        int  old_mode;
        int  ld_len;
        bit  ok;
        bit  len_good;
        old_mode = m_mode;
        m_match  = 0;
        m_err    = 0;
        ld_len   = int'(bus.cfg_len);
        len_good = (ld_len >= 1 && ld_len <= MAX_LEN);
        if (old_mode == 2 && bus.bit_valid) begin
            m_hist.push_back(bus.bit_in);
            if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
            if (m_hist.size() >= m_len) begin
                ok = 1;
                for (int k = 0; k < m_len; k++)
                    if (m_hist[m_hist.size() - 1 - k] !== m_pat[k]) ok = 0;
                if (ok) begin
                    m_match = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (!m_ovl) m_hist.delete();
                end
            end
        end
        if (bus.cfg_load && old_mode != 2) begin
            if (len_good) begin
                m_pat = bus.cfg_pattern; m_len = ld_len; m_ovl = bus.cfg_ovl;
            end else begin
                m_err = 1;
            end
        end
        if (old_mode == 0 && bus.cfg_load && len_good) m_mode = 1;
        else if (old_mode == 1 && bus.start && !bus.stop) begin
            m_mode = 2; m_hist.delete(); m_cnt = 0;
        end else if (old_mode == 2 && bus.stop) m_mode = 1;
    endtask

    task automatic zero_inputs();
        bus.cfg_load = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_ovl = 0;
        bus.start = 0; bus.stop = 0; bus.bit_in = 0; bus.bit_valid = 0;
    endtask

    // one clock: inputs are already applied; advance, update model, compare
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_eq("match",   32'(bus.match),   32'(m_match));
        check_eq("cfg_err", 32'(bus.cfg_err), 32'(m_err));
        check_eq("ready",   32'(bus.ready),   32'(m_mode == 1));
        check_eq("busy",    32'(bus.busy),    32'(m_mode == 2));
`ifdef PATTERN_DET_HIT_CNT_EN
        check_eq("hit_cnt", 32'(hit_cnt),     32'(m_cnt));
`endif
        if (bus.match) pulses++;
        zero_inputs();
    endtask

    task automatic do_load(input logic [7:0] pat, input int len, input bit ovl);
        bus.cfg_load = 1; bus.cfg_pattern = pat; bus.cfg_len = 4'(len); bus.cfg_ovl = ovl;
        step();
    endtask

    task automatic do_start();
        bus.start = 1;
        step();
    endtask

    task automatic do_stop();
        bus.stop = 1;
        step();
    endtask

    task automatic send_bit(input logic b, input int gap);
        bus.bit_in = b; bus.bit_valid = 1;
        step();
        for (int g = 0; g < gap; g++) step();
    endtask

    task automatic do_clear(input string tag);
        clear = 1;
        #2;
        check_eq({tag, "_match"},   32'(bus.match),   32'd0);
        check_eq({tag, "_cfg_err"}, 32'(bus.cfg_err), 32'd0);
        check_eq({tag, "_ready"},   32'(bus.ready),   32'd0);
        check_eq({tag, "_busy"},    32'(bus.busy),    32'd0);
        check_eq({tag, "_state"},   32'(dbg_state),   32'(IDLE));
`ifdef PATTERN_DET_HIT_CNT_EN
        check_eq({tag, "_hit_cnt"}, 32'(hit_cnt),     32'd0);
`endif
        model_reset();
        @(negedge clk);
        clear = 0;
    endtask

    logic [6:0] stream;

    initial begin
        zero_inputs();
        model_reset();
        clear = 0;
        #3;
        do_clear("reset");

        // invalid lengths rejected from IDLE
        do_load(8'h0F, 0, 0);
        check_eq("len0_err", 32'(bus.cfg_err), 32'd1);
        do_load(8'h0F, 9, 0);
        check_eq("len9_err", 32'(bus.cfg_err), 32'd1);
        check_eq("len9_ready", 32'(bus.ready), 32'd0);
        check_eq("len9_state", 32'(dbg_state), 32'(IDLE));

        // 1001 non-overlap, then overlap, on 1,0,0,1,0,0,1
        stream = 7'b1001001;
        for (int mode = 0; mode < 2; mode++) begin
            do_load(8'b1001, 4, bit'(mode));
            do_start();
            pulses = 0;
            for (int i = 6; i >= 0; i--) begin
                send_bit(stream[i], 0);
                if (i == 3) check_eq("bit4_match", 32'(bus.match), 32'd1);
            end
            check_eq(mode ? "ovl_pulses" : "novl_pulses", 32'(pulses), mode ? 32'd2 : 32'd1);
`ifdef PATTERN_DET_HIT_CNT_EN
            check_eq("stream_cnt", 32'(hit_cnt), mode ? 32'd2 : 32'd1);
`endif
            do_stop();
        end

        // gapped bits, then start+stop together from READY
        do_load(8'b1001, 4, 0);
        do_start();
        pulses = 0;
        send_bit(1, 3); send_bit(0, 3); send_bit(0, 3); send_bit(1, 0);
        check_eq("gap_pulses", 32'(pulses), 32'd1);
        do_stop();
        bus.start = 1; bus.stop = 1;
        step();
        check_eq("startstop_ready", 32'(bus.ready), 32'd1);
        check_eq("startstop_busy", 32'(bus.busy), 32'd0);

        // stop coinciding with the completing bit still pulses
        do_load(8'b1, 1, 1);
        do_start();
        bus.bit_in = 1; bus.bit_valid = 1; bus.stop = 1;
        step();
        check_eq("stop_hit_match", 32'(bus.match), 32'd1);

        // clear mid-run discards partial match
        do_load(8'b1001, 4, 0);
        do_start();
        pulses = 0;
        send_bit(1, 0); send_bit(0, 0); send_bit(0, 0);
        do_clear("midrun");
        do_load(8'b1001, 4, 0);
        do_start();
        send_bit(1, 0);
        step();
        check_eq("clear_pulses", 32'(pulses), 32'd0);
`ifdef PATTERN_DET_HIT_CNT_EN
        check_eq("clear_cnt", 32'(hit_cnt), 32'd0);
`endif
        do_stop();

        // saturation of a 2-bit counter with single-bit pattern
        do_load(8'b1, 1, 1);
        do_start();
        pulses = 0;
        for (int i = 0; i < 5; i++) send_bit(1, 0);
        step();
        check_eq("sat_pulses", 32'(pulses), 32'd5);
`ifdef PATTERN_DET_HIT_CNT_EN
        check_eq("sat_cnt", 32'(hit_cnt), 32'd3);
`endif

        // cfg_load during RUN ignored
        bus.cfg_load = 1; bus.cfg_len = 4'd0;
        step();
        check_eq("run_load_err", 32'(bus.cfg_err), 32'd0);
        do_stop();

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_clear("rand_clear");
                continue;
            end
            bus.cfg_load    = ($urandom_range(0, 19) == 0);
            bus.cfg_pattern = 8'($urandom);
            bus.cfg_len     = 4'($urandom_range(0, 9) > 7 ? $urandom_range(0, 15) : $urandom_range(1, 3));
            bus.cfg_ovl     = 1'($urandom);
            bus.start       = ($urandom_range(0, 9) == 0);
            bus.stop        = ($urandom_range(0, 39) == 0);
            bus.bit_in      = 1'($urandom);
            bus.bit_valid   = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
